uart_tx_fifo: RTL and testbench

//  Byte FIFO and feeder stage sitting directly upstream of the UART transmitter.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 23 ++
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: the feeder state encoding and the line-ending bytes.
package uart_pkg;

    typedef enum logic [1:0] {
        s_WAIT_IDLE = 2'd0,
        s_IDLE      = 2'd1,
        s_WAIT_ACT  = 2'd2,
        s_WAIT_DONE = 2'd3
    } feeder_state_e;

    localparam logic [7:0] UART_CR = 8'h0D;
    localparam logic [7:0] UART_LF = 8'h0A;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the transmit FIFO: registered write port, combinational read of the head entry.
module uart_fifo_mem #(
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Wr_En,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [7:0]        i_Wr_Data,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data
);

    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge i_Clock) begin
        if (i_Wr_En) begin
            mem_q[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    assign o_Rd_Data = mem_q[i_Rd_Addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus feeder FSM that hands bytes one at a time to uart_tx.
// Define UART_TX_FIFO_CRLF_EN to expand each LF into a CR,LF pair on the line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    input  logic              i_Clr_Ovf,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    // Reset asserts immediately but is released through two flops so every
    // state register leaves reset on the same clean edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    feeder_state_e     state_q, state_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              full, empty, wr_en, issue, pop, insert_cr;
    logic [7:0]        head_byte;

    uart_fifo_mem #(.ADDR_W(ADDR_W)) u_mem (
        .i_Clock   (i_Clock),
        .i_Wr_En   (wr_en),
        .i_Wr_Addr (wr_ptr_q),
        .i_Wr_Data (i_Wr_Byte),
        .i_Rd_Addr (rd_ptr_q),
        .o_Rd_Data (head_byte)
    );

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign wr_en = i_Wr_DV && !full;
    assign issue = (state_q == s_IDLE) && !empty;
    assign pop   = issue && !insert_cr;

`ifdef UART_TX_FIFO_CRLF_EN
    // A CR is sent ahead of the LF while the LF stays at the head; the flag
    // makes the following issue pop and send the LF itself.
    logic cr_sent_q, cr_sent_d;

    assign insert_cr = issue && (head_byte == UART_LF) && !cr_sent_q;

    always_comb begin
        cr_sent_d = cr_sent_q;
        if (issue) begin
            cr_sent_d = insert_cr;
        end
    end

    always_ff @(posedge i_Clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            cr_sent_q <= 1'b0;
        end else begin
            cr_sent_q <= cr_sent_d;
        end
    end
`else
    assign insert_cr = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 1'b1;
        end
        // A dropped write wins over a same-cycle clear.
        ovf_d = ovf_q;
        if (i_Wr_DV && full) begin
            ovf_d = 1'b1;
        end else if (i_Clr_Ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge i_Clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= s_WAIT_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    // The transmitter is not reset with us, so every frame cycle starts by
    // waiting for it to be fully idle (Active and Done both low).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            s_WAIT_IDLE: if (!i_Tx_Active && !i_Tx_Done) state_d = s_IDLE;
            s_IDLE:      if (!empty)                      state_d = s_WAIT_ACT;
            s_WAIT_ACT:  if (i_Tx_Active)                 state_d = s_WAIT_DONE;
            s_WAIT_DONE: if (i_Tx_Done)                   state_d = s_WAIT_IDLE;
            default:                                      state_d = s_WAIT_IDLE;
        endcase
    end

    always_comb begin
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        if (issue) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = insert_cr ? UART_CR : head_byte;
        end
    end

    assign o_Full     = full;
    assign o_Empty    = empty;
    assign o_Count    = count_q;
    assign o_Overflow = ovf_q;
    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo against a behavioural transmitter that records each accepted byte.
// Expected line contents follow UART_TX_FIFO_CRLF_EN when that macro is defined.
module tb_uart_tx_fifo;

    localparam int ADDR_W = 4;
    localparam int FRAME  = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_dv = 1'b0;
    logic [7:0]        wr_byte = 8'h00;
    logic              clr_ovf = 1'b0;
    logic              o_full, o_empty, o_ovf, o_tx_dv;
    logic [ADDR_W:0]   o_count;
    logic [7:0]        o_tx_byte;

    logic              m_active = 1'b0;
    logic              m_done = 1'b0;
    logic              hold = 1'b0;
    int                m_cnt = 0;
    logic              dv_prev = 1'b0;
    int                viol = 0;
    logic [7:0]        rx_q [$];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (o_full),
        .o_Empty     (o_empty),
        .o_Count     (o_count),
        .o_Overflow  (o_ovf),
        .i_Clr_Ovf   (clr_ovf),
        .o_Tx_DV     (o_tx_dv),
        .o_Tx_Byte   (o_tx_byte),
        .i_Tx_Active (m_active),
        .i_Tx_Done   (m_done)
    );

    // Transmitter model: accepts DV only when idle, Active the cycle after,
    // Done for one cycle at frame end. 'hold' keeps it busy indefinitely.
    always @(posedge clk) begin
        m_done  <= 1'b0;
        dv_prev <= o_tx_dv;
        if (o_tx_dv && (m_active || m_done || dv_prev)) begin
            viol <= viol + 1;
        end
        if (m_active) begin
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end else if (!hold) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end
        end else if (!m_done && (o_tx_dv || hold)) begin
            m_active <= 1'b1;
            m_cnt    <= FRAME;
            if (o_tx_dv) begin
                rx_q.push_back(o_tx_byte);
                $display("tx byte %02h", o_tx_byte);
            end
        end
    end

    typedef struct {
        logic            wr;
        logic [7:0]      data;
        logic            clr;
        logic [ADDR_W:0] count;
        logic            full;
        logic            empty;
        logic            ovf;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic clr,
                                input int cnt, input logic f, input logic e, input logic o);
        vec_t v;
        v.wr = wr; v.data = d; v.clr = clr; v.count = (ADDR_W+1)'(cnt);
        v.full = f; v.empty = e; v.ovf = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_dv = 1'b1; wr_byte = b;
        step();
        wr_dv = 1'b0;
    endtask

    task automatic wait_rx(input int n, input string name);
        int c = 0;
        while (rx_q.size() < n && c < 3000) begin step(); c++; end
        check(name, rx_q.size(), n);
    endtask

    task automatic settle();
        int c = 0;
        while ((m_active || m_done || !o_empty) && c < 3000) begin step(); c++; end
        check("settle_timeout", (c < 3000), 1);
        repeat (4) step();
    endtask

    // Park the transmitter model busy, then reset so the feeder sits in its
    // wait-for-idle state and the FIFO only fills.
    task automatic hold_and_reset();
        int c = 0;
        hold = 1'b1;
        while (!m_active && c < 200) begin step(); c++; end
        check("hold_active", m_active, 1);
        do_reset();
    endtask

    initial begin
        logic [7:0] exp_line [$];
        int ff_seen;
        int c;

        // Reset state, sampled while reset is asserted and before any edge.
        #12 rst_n = 1'b0;
        #1;
        check("rst_count", o_count, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_ovf", o_ovf, 0);
        check("rst_tx_dv", o_tx_dv, 0);
        check("rst_tx_byte", o_tx_byte, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) step();

        // Single byte: count 1 after the write edge, DV with A5 one edge later.
        write_byte(8'hA5);
        check("a5_count_after_wr", o_count, 1);
        check("a5_dv_not_yet", o_tx_dv, 0);
        step();
        check("a5_dv", o_tx_dv, 1);
        check("a5_byte", o_tx_byte, 8'hA5);
        check("a5_count_popped", o_count, 0);
        step();
        check("a5_dv_pulse", o_tx_dv, 0);
        wait_rx(1, "a5_rx_size");
        check("a5_rx", rx_q[0], 8'hA5);
        settle();

        // Async assertion clears the registered byte without a clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_byte", o_tx_byte, 8'h00);
        rst_n = 1'b1;
        repeat (4) step();

        // Fill, overflow and clear, with the transmitter held busy.
        for (int i = 0; i < 16; i++) begin
            vecs[i] = mk(1'b1, 8'(i), 1'b0, i + 1, (i == 15), 1'b0, 1'b0);
        end
        vecs[16] = mk(1'b1, 8'hFF, 1'b0, 16, 1'b1, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 8'h00, 1'b0, 16, 1'b1, 1'b0, 1'b1);
        vecs[18] = mk(1'b1, 8'hFF, 1'b1, 16, 1'b1, 1'b0, 1'b1);
        vecs[19] = mk(1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0);

        rx_q.delete();
        hold_and_reset();
        for (int i = 0; i < NV; i++) begin
            wr_dv = vecs[i].wr; wr_byte = vecs[i].data; clr_ovf = vecs[i].clr;
            step();
            wr_dv = 1'b0; clr_ovf = 1'b0;
            $display("vec %0d wr=%0b data=%02h clr=%0b -> count=%0d full=%0b empty=%0b ovf=%0b",
                     i, vecs[i].wr, vecs[i].data, vecs[i].clr, o_count, o_full, o_empty, o_ovf);
            check($sformatf("vec%0d_count", i), o_count, vecs[i].count);
            check($sformatf("vec%0d_full", i), o_full, vecs[i].full);
            check($sformatf("vec%0d_empty", i), o_empty, vecs[i].empty);
            check($sformatf("vec%0d_ovf", i), o_ovf, vecs[i].ovf);
        end
        hold = 1'b0;
        wait_rx(16, "fill_rx_size");
        settle();
        check("fill_rx_size_final", rx_q.size(), 16);
        ff_seen = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (i < 16) check($sformatf("fill_rx%0d", i), rx_q[i], 8'(i));
            if (rx_q[i] == 8'hFF) ff_seen++;
        end
        check("fill_no_ff", ff_seen, 0);
        check("fill_ovf_cleared", o_ovf, 0);

        // Reset mid-frame: the feeder must wait out the running frame.
        rx_q.delete();
        write_byte(8'h55);
        c = 0;
        while (!m_active && c < 50) begin step(); c++; end
        check("midframe_active", m_active, 1);
        repeat (10) step();
        do_reset();
        write_byte(8'h3C);
        step();
        check("midframe_busy", m_active, 1);
        check("midframe_count_held", o_count, 1);
        check("midframe_no_dv", o_tx_dv, 0);
        wait_rx(2, "midframe_rx_size");
        check("midframe_rx0", rx_q[0], 8'h55);
        check("midframe_rx1", rx_q[1], 8'h3C);
        settle();

        // Line-ending handling.
        rx_q.delete();
`ifdef UART_TX_FIFO_CRLF_EN
        exp_line = '{8'h41, 8'h0D, 8'h0A, 8'h42};
`else
        exp_line = '{8'h41, 8'h0A, 8'h42};
`endif
        write_byte(8'h41);
        write_byte(8'h0A);
        write_byte(8'h42);
        wait_rx(exp_line.size(), "crlf_rx_size");
        settle();
        check("crlf_rx_size_final", rx_q.size(), exp_line.size());
        for (int i = 0; i < exp_line.size(); i++) begin
            check($sformatf("crlf_rx%0d", i), rx_q[i], exp_line[i]);
        end

        // Simultaneous write and pop at count 3.
        rx_q.delete();
        hold_and_reset();
        write_byte(8'h10);
        write_byte(8'h11);
        write_byte(8'h12);
        check("sim_count3", o_count, 3);
        hold = 1'b0;
        c = 0;
        while (!m_done && c < 200) begin step(); c++; end
        check("sim_done_seen", m_done, 1);
        step();                 // feeder sees Done high
        step();                 // feeder sees idle, moves to issue state
        check("sim_count_before", o_count, 3);
        check("sim_dv_before", o_tx_dv, 0);
        write_byte(8'h13);      // this edge both stores 13 and pops 10
        check("sim_count_after", o_count, 3);
        check("sim_dv_after", o_tx_dv, 1);
        check("sim_byte_after", o_tx_byte, 8'h10);
        wait_rx(4, "sim_rx_size");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sim_rx%0d", i), rx_q[i], 8'(8'h10 + i));
        end
        settle();

        check("handshake_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
